// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: state and frame-class
// encodings, the blank code and the row/column to key-code map.
package keypad_pkg;

  localparam logic [4:0] KEY_NONE = 5'h10;

  typedef enum logic [1:0] {
    StIdle,
    StPressChk,
    StPressed,
    StRelChk
  } state_e;

  typedef enum logic [1:0] {
    FrameNone,
    FrameSingle,
    FrameMulti
  } frame_class_e;

  // Codes match the 7-segment digit decoder input (0x0-0xF hex digits).
  function automatic logic [4:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [4:0] code;
    unique case ({row, col})
      4'b00_00: code = 5'h1;
      4'b00_01: code = 5'h2;
      4'b00_10: code = 5'h3;
      4'b00_11: code = 5'hA;
      4'b01_00: code = 5'h4;
      4'b01_01: code = 5'h5;
      4'b01_10: code = 5'h6;
      4'b01_11: code = 5'hB;
      4'b10_00: code = 5'h7;
      4'b10_01: code = 5'h8;
      4'b10_10: code = 5'h9;
      4'b10_11: code = 5'hC;
      4'b11_00: code = 5'hE;
      4'b11_01: code = 5'h0;
      4'b11_10: code = 5'hF;
      4'b11_11: code = 5'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce_fsm.sv
// Frame-level debounce: accepts a single key after DEBOUNCE_SCANS identical frames
// and releases it after DEBOUNCE_SCANS empty frames. No rollover while held.
module keypad_debounce_fsm
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_i,
  input  frame_class_e frame_class_i,
  input  logic [4:0]   frame_code_i,
  output logic [4:0]   key_code_o,
  output logic         key_valid_o,
  output logic         key_down_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_SCANS);
  localparam bit OneScan = (DEBOUNCE_SCANS == 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [4:0]      cand_q, cand_d;
  logic [4:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cand_q      <= KEY_NONE;
      key_code_q  <= KEY_NONE;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    cnt_inc     = (cnt_q >= CntMax) ? cnt_q : cnt_q + 1'b1;
    if (frame_i) begin
      unique case (state_q)
        StIdle: begin
          if (frame_class_i == FrameSingle) begin
            cand_d = frame_code_i;
            cnt_d  = CntW'(1);
            if (OneScan) begin
              key_code_d  = frame_code_i;
              key_valid_d = 1'b1;
              state_d     = StPressed;
            end else begin
              state_d = StPressChk;
            end
          end
        end
        StPressChk: begin
          if (frame_class_i != FrameSingle) begin
            state_d = StIdle;
          end else if (frame_code_i == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CntMax) begin
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              state_d     = StPressed;
            end
          end else begin
            cand_d = frame_code_i;
            cnt_d  = CntW'(1);
          end
        end
        StPressed: begin
          if (frame_class_i == FrameNone) begin
            cnt_d   = CntW'(1);
            state_d = OneScan ? StIdle : StRelChk;
          end
        end
        StRelChk: begin
          if (frame_class_i == FrameNone) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CntMax) state_d = StIdle;
          end else begin
            state_d = StPressed;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    key_code_o  = key_code_q;
    key_valid_o = key_valid_q;
    key_down_o  = (state_q == StPressed) || (state_q == StRelChk);
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column drive, row synchroniser, frame collector
// and debounce FSM producing display-ready key codes.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [4:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);

  logic [DivW-1:0] div_cnt_q;
  logic [1:0]      col_idx_q;
  logic [3:0]      sync1_q, sync2_q;
  logic [1:0]      hits_q, frame_hits;
  logic [4:0]      code_q, frame_code;
  logic [2:0]      col_lows, hit_sum;
  logic [1:0]      low_row;
  logic            sample, frame_end;
  frame_class_e    frame_class;

  assign sample    = (div_cnt_q == DivW'(SCAN_DIV - 1));
  assign frame_end = sample && (col_idx_q == 2'd3);
  assign col_out   = ~(4'b0001 << col_idx_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
    end else begin
      sync1_q <= row_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      col_idx_q <= '0;
    end else if (sample) begin
      div_cnt_q <= '0;
      col_idx_q <= col_idx_q + 2'd1;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  // Merge this column's sample with the running frame so the column-3 sample
  // is classified on the same edge that ends the frame.
  always_comb begin
    col_lows = '0;
    low_row  = '0;
    for (int r = 0; r < 4; r++) begin
      if (!sync2_q[r]) begin
        col_lows = col_lows + 3'd1;
        low_row  = 2'(r);
      end
    end
    hit_sum    = {1'b0, hits_q} + col_lows;
    frame_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    frame_code = (hits_q == 2'd0) ? key_map(low_row, col_idx_q) : code_q;
    unique case (frame_hits)
      2'd0:    frame_class = FrameNone;
      2'd1:    frame_class = FrameSingle;
      default: frame_class = FrameMulti;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q <= '0;
      code_q <= KEY_NONE;
    end else if (sample) begin
      hits_q <= frame_end ? 2'd0 : frame_hits;
      code_q <= frame_code;
    end
  end

  keypad_debounce_fsm #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk          (clk),
    .rst          (rst),
    .frame_i      (frame_end),
    .frame_class_i(frame_class),
    .frame_code_i (frame_code),
    .key_code_o   (key_code),
    .key_valid_o  (key_valid),
    .key_down_o   (key_down)
  );

endmodule
